// File: rtl/mult_acc_pkg.sv
// ============================================================================
// Module : mult_acc_pkg
// Desc   : Shared FSM state encoding and default widths for mult_accumulator
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_acc_pkg;

  localparam int c_WIDTH_DEF = 4;
  localparam int c_CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_acc_ctrl.sv
// ============================================================================
// Module : mult_acc_ctrl
// Desc   : Frame FSM and term counter; handshake flags are registered decodes
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_acc_ctrl
  import mult_acc_pkg::*;
#(
  parameter int CNT_W = c_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_clear,
  output logic             o_accept
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_start_acc;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  assign w_start_acc = i_start && (r_state == IDLE);
  assign w_accept    = i_in_valid && r_in_ready;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_last      = w_accept && (w_cnt_nxt == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_len  <= i_len;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            // An empty frame skips straight to presenting a zero result.
            if (i_len == '0) begin
              r_state     <= OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ACC;
              r_in_ready <= 1'b1;
            end
          end
        end
        ACC: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_state     <= OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_clear     = w_start_acc;
  assign o_accept    = w_accept;

endmodule

`default_nettype wire

// File: rtl/mult_accumulator.sv
// ============================================================================
// Module : mult_accumulator
// Desc   : Sums a framed stream of products with a sticky carry-out flag
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int WIDTH     = c_WIDTH_DEF,
  parameter int CNT_W     = c_CNT_W_DEF,
  parameter int ACC_WIDTH = 2*WIDTH + CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 busy
);

  // One bit wider than the larger addend so any carry past ACC_WIDTH is seen.
  localparam int SUM_W = ((ACC_WIDTH > 2*WIDTH) ? ACC_WIDTH : 2*WIDTH) + 1;

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;

  logic                 w_clear;
  logic                 w_accept;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_carry;

  mult_acc_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_len       (len),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_clear     (w_clear),
    .o_accept    (w_accept)
  );

  assign w_sum   = SUM_W'(r_acc) + SUM_W'(in_prod);
  assign w_carry = |w_sum[SUM_W-1:ACC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum[ACC_WIDTH-1:0];
      if (w_carry) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_sum = r_acc;
  assign out_ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mult_accumulator.sv
// ============================================================================
// Module : tb_mult_accumulator
// Desc   : Directed self-checking bench for mult_accumulator (12- and 8-bit acc)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        out_ready;

  logic        in_ready,  in_ready8;
  logic        out_valid, out_valid8;
  logic [11:0] out_sum;
  logic [7:0]  out_sum8;
  logic        out_ovf,   out_ovf8;
  logic        busy,      busy8;

  int vectors;
  int miscompares;

  mult_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  mult_accumulator #(.ACC_WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_prod   (in_prod),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_sum   (out_sum8),
    .out_ovf   (out_ovf8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input logic [3:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({in_ready, out_valid, out_sum, out_ovf, busy} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
               in_ready, out_valid, out_sum, out_ovf, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] prods [4] = '{8'd0, 8'd6, 8'd225, 8'd24};
    begin_frame(4'd4);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_enter_acc: got rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_prod = prods[i];
      step();
      if (i == 2) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 12'd255 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got vld=%b sum=%0d ovf=%b rdy=%b want 1 255 0 0",
               out_valid, out_sum, out_ovf, in_ready);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_return_idle: got busy=%b vld=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [7:0]  prods [3] = '{8'd143, 8'd14, 8'd15};
    logic [11:0] runs  [3] = '{12'd143, 12'd157, 12'd172};
    begin_frame(4'd3);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_prod  = prods[i];
      step();
      in_valid = 1'b0;
      in_prod  = 8'hFF;
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          step();
          vectors++;
          if (out_sum !== runs[i] || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_stall_%0d_%0d: got sum=%0d vld=%b want %0d 0",
                     i, g, out_sum, out_valid, runs[i]);
          end
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 12'd172 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_result: got vld=%b sum=%0d ovf=%b want 1 172 0",
               out_valid, out_sum, out_ovf);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    begin_frame(4'd2);
    in_valid = 1'b1;
    in_prod  = 8'd225;
    step();
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid8 !== 1'b1 || out_sum8 !== 8'd194 || out_ovf8 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_acc8: got vld=%b sum=%0d ovf=%b want 1 194 1",
               out_valid8, out_sum8, out_ovf8);
    end
    vectors++;
    if (out_sum !== 12'd450 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_acc12: got sum=%0d ovf=%b want 450 0", out_sum, out_ovf);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_ovf8 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky_idle: got %b want 1", out_ovf8);
    end
  endtask

  task automatic test_len_zero();
    begin_frame(4'd0);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 12'd0 || out_ovf !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_result: got vld=%b sum=%0d ovf=%b rdy=%b busy=%b want 1 0 0 0 1",
               out_valid, out_sum, out_ovf, in_ready, busy);
    end
    vectors++;
    if (out_sum8 !== 8'd0 || out_ovf8 !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_clear8: got sum=%0d ovf=%b want 0 0", out_sum8, out_ovf8);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_idle: got busy=%b vld=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    begin_frame(4'd1);
    in_valid = 1'b1;
    in_prod  = 8'd7;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 4'd3;
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 12'd7 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d: got vld=%b sum=%0d rdy=%b want 1 7 0",
                 i, out_valid, out_sum, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_start_ignored: got busy=%b rdy=%b vld=%b want 0 0 0",
               busy, in_ready, out_valid);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_stay_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    begin_frame(4'd4);
    in_valid = 1'b1;
    in_prod  = 8'd9;
    step();
    in_prod  = 8'd10;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_sum !== 12'd19) begin
      miscompares++;
      $display("FAIL midrst_partial: got sum=%0d want 19", out_sum);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_sum, out_ovf, busy} !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_async: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
               in_ready, out_valid, out_sum, out_ovf, busy);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_no_pulse_%0d: got vld=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    begin_frame(4'd1);
    in_valid = 1'b1;
    in_prod  = 8'd5;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 12'd5 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_next_frame: got vld=%b sum=%0d ovf=%b want 1 5 0",
               out_valid, out_sum, out_ovf);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    len         = 4'd0;
    in_valid    = 1'b0;
    in_prod     = 8'd0;
    out_ready   = 1'b0;

    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_len_zero();
    test_back_to_back();
    test_mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the multiplier operand width; products are 2*WIDTH bits.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the term counter and of len.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 2*WIDTH+CNT_W (12), giving the accumulator width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port start, input, 1 bit: a frame-start pulse, sampled only in IDLE.
REQ-007 Port len, input, CNT_W bits: the number of products in the frame, latched on an accepted start.
REQ-008 Port in_valid, input, 1 bit: the product source has valid data.
REQ-009 Port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-010 Port in_prod, input, 2*WIDTH bits: the product from the upstream combinational multiplier (P).
REQ-011 Port out_valid, output, 1 bit: out_sum and out_ovf are valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port out_sum, output, ACC_WIDTH bits: the accumulated sum, modulo 2^ACC_WIDTH.
REQ-014 Port out_ovf, output, 1 bit: sticky flag meaning a carry left the accumulator during the frame.
REQ-015 Port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACC and OUT.
REQ-017 In IDLE, start=1 SHALL latch len, clear acc, cnt and ovf, and move to ACC, or to OUT if len==0.
REQ-018 start SHALL be ignored in ACC and OUT.
REQ-019 in_ready SHALL be 1 only in ACC; it is registered state decode with no combinational path from in_valid.
REQ-020 On in_valid & in_ready: acc <= acc + zero-extended in_prod, and cnt <= cnt + 1.
REQ-021 When the accepted product is the len-th, the next state SHALL be OUT; out_valid rises the cycle after the final handshake (latency 1).
REQ-022 If acc + in_prod >= 2^ACC_WIDTH, acc SHALL wrap modulo 2^ACC_WIDTH and ovf SHALL set and stay set until the next accepted start.
REQ-023 out_valid SHALL be 1 only in OUT; out_sum and out_ovf SHALL hold stable while out_valid & !out_ready.
REQ-024 On out_valid & out_ready the FSM SHALL return to IDLE; a start in that same cycle SHALL be ignored.
REQ-025 A len==0 frame SHALL produce out_sum=0 and out_ovf=0 in OUT one cycle after start.
REQ-026 busy SHALL be 1 in ACC and OUT.
REQ-027 in_valid=0 cycles in ACC SHALL stall without changing acc or cnt.

Reset
REQ-028 While rst=1: state=IDLE, acc=0, cnt=0, ovf=0, latched len=0.
REQ-029 Resulting output values: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial sum; no out_valid pulse follows the reset.

Structure
REQ-031 Package mult_acc_pkg SHALL hold the state enum (IDLE/ACC/OUT) and the default WIDTH/CNT_W constants.
REQ-032 The FSM and counter SHALL live in sub-module mult_acc_ctrl; the accumulator register and adder stay in the top.
REQ-033 The multiplier SHALL remain external and feed in_prod directly.

Verification
REQ-034 Reset mid-ACC after 2 products -> outputs return to reset values; the next frame with len=1, prod=5 yields out_sum=5.
REQ-035 start with len=4, products 0, 6, 225, 24, in_valid always high -> out_valid 1 cycle after the 4th handshake, out_sum=255, out_ovf=0.
REQ-036 len=3, products 143, 14, 15 with in_valid gaps of 2 cycles -> out_sum=172; acc is unchanged during the gaps.
REQ-037 ACC_WIDTH=8, len=2, products 225, 225 -> out_sum=194, out_ovf=1.
REQ-038 out_ready held low 5 cycles -> out_sum stable and in_ready=0; start pulses during OUT are ignored.
REQ-039 len=0 start -> out_valid next cycle with out_sum=0; out_ready=1 returns the FSM to IDLE.
